// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and helpers for the program-counter sequencer
package pc_seq_pkg;

   typedef enum logic [2:0] {
      BOOT,
      BOOT_LD,
      RUN,
      INT_RD,
      INT_LD
   } pc_state_t;

   localparam int DEF_RST_VEC_PTR = 0;
   localparam int DEF_INT_VEC_PTR = 1;

   // MSB of external source k inside the packed source bus (source 1 sits at the bottom).
   function automatic int src_msb(input int k, input int w);
      return k * w - 1;
   endfunction

endpackage

// File: rtl/pc_int_pending.sv
// rtl/pc_int_pending.sv - interrupt request edge detect and pending flag
module pc_int_pending (
   input  logic clk,
   input  logic rst,
   input  logic int_req,
   input  logic take,
   output logic pend
);

   logic int_q;
   logic rise;

   assign rise = int_req & ~int_q;

   // A fresh edge in the take cycle must survive, so set outranks clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q <= 1'b0;
         pend  <= 1'b0;
      end else begin
         int_q <= int_req;
         if (rise)
            pend <= 1'b1;
         else if (take)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered PC sequencer with vectored boot and interrupt entry
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int NSRC        = 4,
   parameter int SEL_W       = 2,
   parameter int RST_VEC_PTR = DEF_RST_VEC_PTR,
   parameter int INT_VEC_PTR = DEF_INT_VEC_PTR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [SEL_W-1:0]         sel,
   input  logic [(NSRC-1)*ADDR_W-1:0] src_data,
   input  logic                     int_req,
   input  logic                     int_en,
   input  logic [ADDR_W-1:0]        vec_data,
   output logic                     vec_rd_en,
   output logic [ADDR_W-1:0]        vec_addr,
   output logic [ADDR_W-1:0]        pc,
   output logic                     pc_valid,
   output logic [ADDR_W-1:0]        ret_addr,
   output logic                     int_ack
);

   pc_state_t         state;
   pc_state_t         state_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] src_next;
   logic              pend;
   logic              take;

   pc_int_pending u_pending (
      .clk     (clk),
      .rst     (rst),
      .int_req (int_req),
      .take    (take),
      .pend    (pend)
   );

   // Out-of-range selects fall through to a hold.
   always_comb begin
      src_next = pc;
      if (sel == '0) begin
         src_next = pc + ADDR_W'(1);
      end else begin
         for (int k = 1; k < NSRC; k++) begin
            if (sel == SEL_W'(k))
               src_next = src_data[src_msb(k, ADDR_W) -: ADDR_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      take      = 1'b0;
      vec_rd_en = 1'b0;
      vec_addr  = ADDR_W'(RST_VEC_PTR);
      pc_valid  = 1'b0;
      case (state)
         BOOT: begin
            vec_rd_en = 1'b1;
            state_nxt = BOOT_LD;
         end
         BOOT_LD: begin
            pc_nxt    = vec_data;
            state_nxt = RUN;
         end
         RUN: begin
            pc_valid = 1'b1;
            if (pend && int_en && !stall) begin
               take      = 1'b1;
               state_nxt = INT_RD;
            end else if (!stall) begin
               pc_nxt = src_next;
            end
         end
         INT_RD: begin
            vec_rd_en = 1'b1;
            vec_addr  = ADDR_W'(INT_VEC_PTR);
            state_nxt = INT_LD;
         end
         INT_LD: begin
            pc_nxt    = vec_data;
            state_nxt = RUN;
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= BOOT;
         pc       <= '0;
         ret_addr <= '0;
         int_ack  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         int_ack <= take;
         if (take)
            ret_addr <= pc;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  sel;
   logic [23:0] src_data;
   logic        int_req;
   logic        int_en;
   logic [7:0]  vec_data;
   logic        vec_rd_en;
   logic [7:0]  vec_addr;
   logic [7:0]  pc;
   logic        pc_valid;
   logic [7:0]  ret_addr;
   logic        int_ack;

   logic        stall2;
   logic [1:0]  sel2;
   logic [7:0]  src_data2;
   logic        int_req2;
   logic        int_en2;
   logic [7:0]  vec_data2;
   logic        vec_rd_en2;
   logic [7:0]  vec_addr2;
   logic [7:0]  pc2;
   logic        pc_valid2;
   logic [7:0]  ret_addr2;
   logic        int_ack2;

   logic [7:0]  mem [0:3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(8), .NSRC(4), .SEL_W(2), .RST_VEC_PTR(0), .INT_VEC_PTR(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .sel(sel), .src_data(src_data),
      .int_req(int_req), .int_en(int_en), .vec_data(vec_data),
      .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .pc(pc), .pc_valid(pc_valid),
      .ret_addr(ret_addr), .int_ack(int_ack)
   );

   pc_sequencer #(.ADDR_W(8), .NSRC(2), .SEL_W(2), .RST_VEC_PTR(0), .INT_VEC_PTR(1)) dut2 (
      .clk(clk), .rst(rst), .stall(stall2), .sel(sel2), .src_data(src_data2),
      .int_req(int_req2), .int_en(int_en2), .vec_data(vec_data2),
      .vec_rd_en(vec_rd_en2), .vec_addr(vec_addr2), .pc(pc2), .pc_valid(pc_valid2),
      .ret_addr(ret_addr2), .int_ack(int_ack2)
   );

   // Synchronous vector memory: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (vec_rd_en)
         vec_data <= mem[vec_addr[1:0]];
   end

   assign vec_data2 = 8'h10;

   typedef struct {
      logic       stall;
      logic [1:0] sel;
      logic [7:0] s1;
      logic [7:0] s2;
      logic [7:0] s3;
      logic [7:0] exp_pc;
   } vec_t;

   vec_t tbl [9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b0, 2'd1, 8'hFE, 8'h00, 8'h00, 8'hFE};
      tbl[1] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF};
      tbl[2] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h01};
      tbl[4] = '{1'b0, 2'd2, 8'h00, 8'h7A, 8'h00, 8'h7A};
      tbl[5] = '{1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h7A};
      tbl[6] = '{1'b1, 2'd2, 8'h00, 8'h11, 8'h00, 8'h7A};
      tbl[7] = '{1'b0, 2'd3, 8'h00, 8'h00, 8'h23, 8'h23};
      tbl[8] = '{1'b1, 2'd1, 8'h55, 8'h00, 8'h00, 8'h23};

      mem[0] = 8'h40; mem[1] = 8'h90; mem[2] = 8'h00; mem[3] = 8'h00;
      rst = 1'b1; stall = 1'b1; sel = 2'd0; src_data = '0; int_req = 1'b0; int_en = 1'b1;
      stall2 = 1'b0; sel2 = 2'd2; src_data2 = 8'h00; int_req2 = 1'b0; int_en2 = 1'b0;

      step(); step();
      chk("rst_pc", pc, 8'h00);
      chk("rst_pc_valid", pc_valid, 1'b0);
      chk("rst_vec_rd_en", vec_rd_en, 1'b1);
      chk("rst_vec_addr", vec_addr, 8'h00);
      chk("rst_ret_addr", ret_addr, 8'h00);
      chk("rst_int_ack", int_ack, 1'b0);

      rst = 1'b0;
      step();
      chk("boot1_pc_valid", pc_valid, 1'b0);
      chk("boot1_vec_rd_en", vec_rd_en, 1'b0);
      step();
      chk("boot2_pc", pc, 8'h40);
      chk("boot2_pc_valid", pc_valid, 1'b1);
      step();
      chk("boot3_pc", pc, 8'h40);
      chk("boot3_pc_valid", pc_valid, 1'b1);

      chk("n2_boot_pc", pc2, 8'h10);
      chk("n2_boot_valid", pc_valid2, 1'b1);
      sel2 = 2'd1; src_data2 = 8'h33;
      step();
      chk("n2_sel1", pc2, 8'h33);
      sel2 = 2'd2;
      step();
      chk("n2_sel2_hold", pc2, 8'h33);
      sel2 = 2'd3;
      step();
      chk("n2_sel3_hold", pc2, 8'h33);
      sel2 = 2'd0;
      step();
      chk("n2_sel0_inc", pc2, 8'h34);
      sel2 = 2'd2;

      for (int i = 0; i < 9; i++) begin
         stall    = tbl[i].stall;
         sel      = tbl[i].sel;
         src_data = {tbl[i].s3, tbl[i].s2, tbl[i].s1};
         step();
         chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
         chk($sformatf("vec%0d_valid", i), pc_valid, 1'b1);
      end

      stall = 1'b0; sel = 2'd3; src_data = {8'h23, 8'h00, 8'h00}; int_en = 1'b1; int_req = 1'b1;
      step();
      chk("irq_a_ack", int_ack, 1'b0);
      chk("irq_a_pc", pc, 8'h23);
      step();
      chk("irq_b_ack", int_ack, 1'b1);
      chk("irq_b_ret", ret_addr, 8'h23);
      chk("irq_b_valid", pc_valid, 1'b0);
      chk("irq_b_rd_en", vec_rd_en, 1'b1);
      chk("irq_b_vaddr", vec_addr, 8'h01);
      chk("irq_b_pc", pc, 8'h23);
      step();
      chk("irq_c_ack", int_ack, 1'b0);
      chk("irq_c_valid", pc_valid, 1'b0);
      chk("irq_c_rd_en", vec_rd_en, 1'b0);
      step();
      chk("irq_d_pc", pc, 8'h90);
      chk("irq_d_valid", pc_valid, 1'b1);
      chk("irq_d_ack", int_ack, 1'b0);

      src_data = {8'h90, 8'h00, 8'h00};
      int_req = 1'b0; stall = 1'b1;
      step();
      int_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("stall_noack%0d", i), int_ack, 1'b0);
      end
      stall = 1'b0; int_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("dis_noack%0d", i), int_ack, 1'b0);
      end
      int_req = 1'b0; int_en = 1'b1;
      step();
      chk("late_ack", int_ack, 1'b1);
      chk("late_ret", ret_addr, 8'h90);
      int_req = 1'b1;
      step();
      chk("nest_c_ack", int_ack, 1'b0);
      step();
      chk("nest_d_pc", pc, 8'h90);
      chk("nest_d_ack", int_ack, 1'b0);
      int_req = 1'b0;
      step();
      chk("second_ack", int_ack, 1'b1);
      chk("second_ret", ret_addr, 8'h90);
      int_req = 1'b1;
      step();
      chk("intld_valid", pc_valid, 1'b0);

      rst = 1'b1;
      #1;
      chk("arst_pc", pc, 8'h00);
      chk("arst_valid", pc_valid, 1'b0);
      chk("arst_rd_en", vec_rd_en, 1'b1);
      chk("arst_vaddr", vec_addr, 8'h00);
      chk("arst_ret", ret_addr, 8'h00);
      chk("arst_ack", int_ack, 1'b0);
      int_req = 1'b0;
      step();
      rst = 1'b0;
      step(); step();
      chk("reboot_pc", pc, 8'h40);
      chk("reboot_valid", pc_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("reboot_noack%0d", i), int_ack, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
